// File: rtl/keygen_pkg.sv
// Shared constants for the key-generation matrix sequencer: default code
// parameters, FSM state encodings, operand/result select codes and a width helper.
package keygen_pkg;

   // Default code parameters (prime Q, correctable errors T) and derived sizes
   localparam int unsigned Q_DEF  = 19;
   localparam int unsigned T_DEF  = 10;
   localparam int unsigned NR_DEF = Q_DEF * Q_DEF;
   localparam int unsigned KC_DEF = NR_DEF + 2 * T_DEF * Q_DEF;

   // FSM state encoding
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_GP_ISSUE  = 3'd1;
   localparam logic [2:0] ST_GP_DRAIN  = 3'd2;
   localparam logic [2:0] ST_SGP_ISSUE = 3'd3;
   localparam logic [2:0] ST_SGP_DRAIN = 3'd4;
   localparam logic [2:0] ST_DONE      = 3'd5;

   // op_sel / wr_sel codes
   localparam logic SEL_GP  = 1'b0;
   localparam logic SEL_SGP = 1'b1;

   // Bits needed to index n items; never less than one bit
   function automatic int unsigned addr_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/keygen_tag_pipe.sv
// Result tag pipeline: tracks {valid, sel, addr} for every issued operand pair
// so that the write address lines up with the datapath result LAT cycles later.
module keygen_tag_pipe #(
   parameter int unsigned LAT = 2,
   parameter int unsigned AW  = 5
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          flush,
   input  logic          push_valid,
   input  logic          push_sel,
   input  logic [AW-1:0] push_addr,
   output logic          head_valid,
   output logic          head_sel,
   output logic [AW-1:0] head_addr,
   output logic          tail_empty
);

   logic [LAT-1:0] vld_q;
   logic [LAT-1:0] sel_q;
   logic [AW-1:0]  addr_q [LAT];

   // Shift every cycle; flush discards all in-flight tags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_q <= '0;
         sel_q <= '0;
         for (int i = 0; i < LAT; i++) addr_q[i] <= '0;
      end else if (flush) begin
         vld_q <= '0;
         sel_q <= '0;
         for (int i = 0; i < LAT; i++) addr_q[i] <= '0;
      end else begin
         vld_q[0]  <= push_valid;
         sel_q[0]  <= push_sel;
         addr_q[0] <= push_addr;
         for (int i = 1; i < LAT; i++) begin
            vld_q[i]  <= vld_q[i-1];
            sel_q[i]  <= sel_q[i-1];
            addr_q[i] <= addr_q[i-1];
         end
      end
   end

   // tail_empty: nothing behind the head, so the pipe empties after this cycle
   always_comb begin
      tail_empty = 1'b1;
      for (int i = 0; i < int'(LAT) - 1; i++) begin
         if (vld_q[i]) tail_empty = 1'b0;
      end
   end

   assign head_valid = vld_q[LAT-1];
   assign head_sel   = sel_q[LAT-1];
   assign head_addr  = addr_q[LAT-1];

endmodule

// File: rtl/keygen_mat_sched.sv
// Key-generation matrix sequencer: issues G.P then S.GP operand addresses,
// tracks results through the dot-product latency and generates write addresses.
module keygen_mat_sched
   import keygen_pkg::*;
#(
   parameter int unsigned Q   = Q_DEF,
   parameter int unsigned T   = T_DEF,
   parameter int unsigned LAT = 2,
   // Derived sizes; not meant to be overridden
   parameter int unsigned NR  = Q * Q,
   parameter int unsigned KC  = NR + 2 * T * Q,
   parameter int unsigned RW  = addr_w(NR),
   parameter int unsigned CW  = addr_w(KC),
   parameter int unsigned AW  = addr_w(NR * KC)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic          abort,
   input  logic          mats_ready,
   input  logic          op_ready,
   input  logic          res_valid,
   output logic          op_valid,
   output logic          op_sel,
   output logic [RW-1:0] g_row_addr,
   output logic [CW-1:0] p_col_addr,
   output logic [RW-1:0] s_row_addr,
   output logic [CW-1:0] gp_col_addr,
   output logic          wr_en,
   output logic          wr_sel,
   output logic [AW-1:0] wr_addr,
   output logic          busy,
   output logic          done,
   output logic          err
);

   logic [2:0]    state_q, state_d;
   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic [AW-1:0] tag_q, tag_d;
   logic          err_q, err_d;

   logic          in_gp, in_sgp, issue, issue_sel;
   logic          row_last, col_last, mismatch;
   logic          pipe_valid, pipe_sel, pipe_drained;
   logic [AW-1:0] pipe_addr;

   assign in_gp     = (state_q == ST_GP_ISSUE);
   assign in_sgp    = (state_q == ST_SGP_ISSUE);
   assign issue     = (in_gp || in_sgp) && op_ready && !abort;
   assign issue_sel = in_sgp ? SEL_SGP : SEL_GP;
   assign row_last  = (row_q == RW'(NR - 1));
   assign col_last  = (col_q == CW'(KC - 1));
   assign mismatch  = (res_valid != pipe_valid);

   keygen_tag_pipe #(
      .LAT (LAT),
      .AW  (AW)
   ) u_tag_pipe (
      .clk        (clk),
      .reset_n    (reset_n),
      .flush      (abort),
      .push_valid (issue),
      .push_sel   (issue_sel),
      .push_addr  (tag_q),
      .head_valid (pipe_valid),
      .head_sel   (pipe_sel),
      .head_addr  (pipe_addr),
      .tail_empty (pipe_drained)
   );

   // Next-state: FSM, row/col counters and running write-address tag
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      tag_d   = tag_q;
      err_d   = err_q;
      if (abort) begin
         state_d = ST_IDLE;
         row_d   = '0;
         col_d   = '0;
         tag_d   = '0;
      end else begin
         if (mismatch) err_d = 1'b1;
         case (state_q)
            ST_IDLE: begin
               if (start && mats_ready) begin
                  state_d = ST_GP_ISSUE;
                  err_d   = 1'b0;
                  row_d   = '0;
                  col_d   = '0;
                  tag_d   = '0;
               end
            end
            // Row-major walk; tag steps by NR down a GP column, restarts at r+1
            ST_GP_ISSUE: begin
               if (op_ready) begin
                  if (col_last) begin
                     col_d = '0;
                     if (row_last) begin
                        row_d   = '0;
                        tag_d   = '0;
                        state_d = ST_GP_DRAIN;
                     end else begin
                        row_d = row_q + 1'b1;
                        tag_d = AW'(row_q) + AW'(1);
                     end
                  end else begin
                     col_d = col_q + 1'b1;
                     tag_d = tag_q + AW'(NR);
                  end
               end
            end
            ST_GP_DRAIN: begin
               if (pipe_drained) state_d = ST_SGP_ISSUE;
            end
            // Column-major walk; tag is simply sequential
            ST_SGP_ISSUE: begin
               if (op_ready) begin
                  tag_d = tag_q + AW'(1);
                  if (row_last) begin
                     row_d = '0;
                     if (col_last) begin
                        col_d   = '0;
                        tag_d   = '0;
                        state_d = ST_SGP_DRAIN;
                     end else begin
                        col_d = col_q + 1'b1;
                     end
                  end else begin
                     row_d = row_q + 1'b1;
                  end
               end
            end
            ST_SGP_DRAIN: begin
               if (pipe_drained) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         row_q   <= '0;
         col_q   <= '0;
         tag_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         tag_q   <= tag_d;
         err_q   <= err_d;
      end
   end

   // Outputs: addresses only driven in their own phase; writes only for expected results
   always_comb begin
      op_valid    = issue;
      op_sel      = in_sgp ? SEL_SGP : SEL_GP;
      g_row_addr  = in_gp  ? row_q : '0;
      p_col_addr  = in_gp  ? col_q : '0;
      s_row_addr  = in_sgp ? row_q : '0;
      gp_col_addr = in_sgp ? col_q : '0;
      wr_en       = res_valid && pipe_valid && !abort;
      wr_sel      = wr_en ? pipe_sel : SEL_GP;
      wr_addr     = wr_en ? pipe_addr : '0;
      busy        = (state_q != ST_IDLE);
      done        = (state_q == ST_DONE) && !abort;
      err         = err_q;
   end

endmodule

// File: tb/tb_keygen_mat_sched.sv
// Scoreboard bench for keygen_mat_sched with Q=2, T=1 (NR=4, KC=8, LAT=2).
// A datapath model computes the dot products from the issued addresses; a
// negedge monitor pops expected ops/writes and checks them.
module tb_keygen_mat_sched;

   localparam int NR  = 4;
   localparam int KC  = 8;
   localparam int LAT = 2;

   logic       clk = 1'b0;
   logic       reset_n, start, abort, mats_ready, op_ready, res_valid;
   logic       op_valid, op_sel, wr_en, wr_sel, busy, done, err;
   logic [1:0] g_row_addr, s_row_addr;
   logic [2:0] p_col_addr, gp_col_addr;
   logic [4:0] wr_addr;

   keygen_mat_sched #(
      .Q   (2),
      .T   (1),
      .LAT (LAT)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .abort       (abort),
      .mats_ready  (mats_ready),
      .op_ready    (op_ready),
      .res_valid   (res_valid),
      .op_valid    (op_valid),
      .op_sel      (op_sel),
      .g_row_addr  (g_row_addr),
      .p_col_addr  (p_col_addr),
      .s_row_addr  (s_row_addr),
      .gp_col_addr (gp_col_addr),
      .wr_en       (wr_en),
      .wr_sel      (wr_sel),
      .wr_addr     (wr_addr),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   always #5 clk = ~clk;

   // Matrices: G rows (bit k = column k), P columns (bit k = row k), S rows (bit i)
   logic [7:0] g_rows [NR] = '{8'hB5, 8'h3C, 8'h96, 8'h47};
   logic [7:0] p_cols [KC] = '{8'h81, 8'h42, 8'hE7, 8'h18, 8'h5A, 8'hC3, 8'h24, 8'h99};
   logic [3:0] s_rows [NR] = '{4'b1011, 4'b0110, 4'b1101, 4'b0011};
   logic [3:0] gp_ref  [KC], key_ref [KC];
   logic [3:0] gp_mem  [KC], key_mem [KC];

   int checks = 0, errors = 0;
   logic [5:0] op_q [$];
   logic [5:0] wr_q [$];
   int run_cyc, done_cnt, done_cyc, gp_wr_cnt, gp_ops, sgp_ops;
   bit sgp_seen;

   // Datapath model state
   logic [LAT-1:0] pv, pb;
   logic cap_v, cap_b, cap_abort, res_bit, inj_req;

   task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic dot_g(input int r, input int c);
      return ^(g_rows[r] & p_cols[c]);
   endfunction

   function automatic logic dot_s(input int r, input int c);
      return ^(s_rows[r] & gp_mem[c]);
   endfunction

   // Datapath model: capture the op mid-cycle, present its result LAT cycles later
   initial begin
      cap_v = 0; cap_b = 0; cap_abort = 0;
      forever begin
         @(negedge clk);
         cap_v     = op_valid;
         cap_b     = op_valid ? (op_sel ? dot_s(int'(s_row_addr), int'(gp_col_addr))
                                        : dot_g(int'(g_row_addr), int'(p_col_addr))) : 1'b0;
         cap_abort = abort;
      end
   end

   initial begin
      pv = '0; pb = '0; res_valid = 0; res_bit = 0; inj_req = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!reset_n || cap_abort) begin
            pv = '0; pb = '0; res_valid = 0; res_bit = 0;
         end else begin
            for (int j = LAT - 1; j > 0; j--) begin
               pv[j] = pv[j-1];
               pb[j] = pb[j-1];
            end
            pv[0]     = cap_v;
            pb[0]     = cap_b;
            res_valid = pv[LAT-1] | inj_req;
            res_bit   = pb[LAT-1];
            inj_req   = 0;
         end
      end
   end

   // Monitor / scoreboard
   initial begin
      logic [5:0] cur, expv;
      int c, r;
      forever begin
         @(negedge clk);
         run_cyc++;
         if (op_valid) begin
            cur = {op_sel, op_sel ? s_row_addr : g_row_addr, op_sel ? gp_col_addr : p_col_addr};
            if (op_sel) begin
               if (!sgp_seen) begin
                  chk_eq("sgp_after_gp_complete", gp_wr_cnt, 32);
                  sgp_seen = 1;
               end
               sgp_ops++;
            end else begin
               gp_ops++;
            end
            if (op_q.size() == 0) chk_eq("op_unexpected", {31'd0, op_valid}, 0);
            else begin
               expv = op_q.pop_front();
               chk_eq("op_seq", {26'd0, cur}, {26'd0, expv});
            end
         end
         if (wr_en) begin
            cur = {wr_sel, wr_addr};
            if (wr_q.size() == 0) chk_eq("wr_unexpected", {31'd0, wr_en}, 0);
            else begin
               expv = wr_q.pop_front();
               chk_eq("wr_seq", {26'd0, cur}, {26'd0, expv});
            end
            c = int'(wr_addr) / NR;
            r = int'(wr_addr) % NR;
            if (wr_sel) key_mem[c][r] = res_bit;
            else begin
               gp_mem[c][r] = res_bit;
               gp_wr_cnt++;
            end
         end
         if (done) begin
            done_cnt++;
            done_cyc = run_cyc;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Push the expected op and write sequences, then pulse start
   task automatic begin_run();
      op_q.delete();
      wr_q.delete();
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < KC; c++) begin
            op_q.push_back({1'b0, 2'(r), 3'(c)});
            wr_q.push_back({1'b0, 5'(c * NR + r)});
         end
      for (int c = 0; c < KC; c++)
         for (int i = 0; i < NR; i++) begin
            op_q.push_back({1'b1, 2'(i), 3'(c)});
            wr_q.push_back({1'b1, 5'(c * NR + i)});
         end
      for (int c = 0; c < KC; c++) begin
         gp_mem[c]  = '0;
         key_mem[c] = '0;
      end
      done_cnt = 0; gp_wr_cnt = 0; gp_ops = 0; sgp_ops = 0; sgp_seen = 0; run_cyc = 0;
      start = 1; mats_ready = 1; op_ready = 1;
      tick();
      start = 0;
      chk_eq("busy_after_start", {31'd0, busy}, 1);
      chk_eq("err_cleared_by_start", {31'd0, err}, 0);
   endtask

   task automatic run_full(input bit toggle);
      int n;
      begin_run();
      n = 0;
      while (done_cnt == 0 && n < 400) begin
         op_ready = toggle ? !op_ready : 1'b1;
         tick();
         n++;
      end
      op_ready = 1;
      chk_eq("done_seen", {31'd0, done_cnt != 0}, 1);
      repeat (3) tick();
      chk_eq("done_once", done_cnt, 1);
      if (toggle) chk_eq("done_later", {31'd0, done_cyc > 70}, 1);
      else        chk_eq("done_cycle", done_cyc, 70);
      chk_eq("ops_left", op_q.size(), 0);
      chk_eq("writes_left", wr_q.size(), 0);
      chk_eq("err_after_run", {31'd0, err}, 0);
      chk_eq("busy_after_done", {31'd0, busy}, 0);
      for (int c = 0; c < KC; c++) begin
         chk_eq($sformatf("gp_col%0d", c), {28'd0, gp_mem[c]}, {28'd0, gp_ref[c]});
         chk_eq($sformatf("key_col%0d", c), {28'd0, key_mem[c]}, {28'd0, key_ref[c]});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int n;
      // Reference GP = G*P and key = S*GP over GF(2)
      for (int c = 0; c < KC; c++)
         for (int i = 0; i < NR; i++) gp_ref[c][i] = dot_g(i, c);
      for (int c = 0; c < KC; c++)
         for (int r = 0; r < NR; r++) key_ref[c][r] = ^(s_rows[r] & gp_ref[c]);

      reset_n = 0; start = 0; abort = 0; mats_ready = 0; op_ready = 0;
      tick();
      tick();
      chk_eq("reset_outputs", {27'd0, busy, op_valid, wr_en, done, err}, 0);
      reset_n = 1;
      tick();

      // 1: straight run; 2: op_ready toggling
      run_full(0);
      run_full(1);

      // 4: abort at SGP op 10, then a clean restart
      begin_run();
      n = 0;
      while (sgp_ops < 10 && n < 200) begin
         tick();
         n++;
      end
      chk_eq("abort_reached_sgp10", sgp_ops, 10);
      abort = 1;
      #1;
      chk_eq("abort_gates_op", {31'd0, op_valid}, 0);
      tick();
      abort = 0;
      op_q.delete();
      wr_q.delete();
      chk_eq("abort_idle", {31'd0, busy}, 0);
      repeat (10) tick();
      chk_eq("abort_no_done", done_cnt, 0);
      chk_eq("abort_no_err", {31'd0, err}, 0);
      run_full(0);

      // 5: stray result with empty tag pipe
      inj_req = 1;
      tick();
      chk_eq("inject_no_wr", {31'd0, wr_en}, 0);
      tick();
      chk_eq("err_set", {31'd0, err}, 1);
      repeat (3) tick();
      chk_eq("err_sticky", {31'd0, err}, 1);
      run_full(0);

      // 6: asynchronous reset mid-GP
      begin_run();
      n = 0;
      while (gp_ops < 10 && n < 200) begin
         tick();
         n++;
      end
      chk_eq("pre_reset_op_valid", {31'd0, op_valid}, 1);
      #1;
      reset_n = 0;
      #1;
      chk_eq("reset_async_outputs",
             {16'd0, busy, op_valid, wr_en, done, err, op_sel, g_row_addr, p_col_addr, wr_addr}, 0);
      tick();
      reset_n = 1;
      op_q.delete();
      wr_q.delete();
      start = 1; mats_ready = 0;
      tick();
      start = 0;
      chk_eq("start_no_mats", {31'd0, busy}, 0);
      tick();
      chk_eq("still_idle", {31'd0, busy}, 0);
      run_full(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
